// File: rtl/soda_machine_types.sv
// Shared types and defaults for the soda machine: dispenser FSM states, timing defaults,
// and the saturating pending-coin counter update.
package soda_machine_types;

  typedef enum logic [2:0] {
    IDLE,
    EJECT1,
    EJECT2,
    GAP,
    FAULT
  } dispense_state_type;

  localparam int DEFAULT_POUR_CYCLES   = 8;
  localparam int DEFAULT_EJECT_TIMEOUT = 16;

  // Net update of a 3-bit pending counter; clamps at 7 so excess requests are dropped.
  function automatic logic [2:0] sat_update(input logic [2:0] cnt,
                                            input logic [1:0] inc,
                                            input logic       dec);
    logic [3:0] sum;
    sum = {1'b0, cnt} + {2'b00, inc};
    if (dec && (sum != 4'd0)) sum = sum - 4'd1;
    return (sum > 4'd7) ? 3'd7 : sum[2:0];
  endfunction

endpackage

// File: rtl/one_shot_timer.sv
// Reloadable down-counter: load sets LOAD_VALUE, active is high while the count is nonzero.
// Active rises the cycle after load and stays high exactly LOAD_VALUE cycles; reload extends it.
module one_shot_timer #(
  parameter int WIDTH      = 8,
  parameter int LOAD_VALUE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active,
  output logic active_next
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = WIDTH'(LOAD_VALUE);
    end else if (count != '0) begin
      count_next = count - WIDTH'(1);
    end
    active_next = (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= '0;
      active <= 1'b0;
    end else begin
      count  <= count_next;
      active <= active_next;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin-change and water-valve controller: queues coin requests, runs hopper motors one coin
// at a time with sensor handshake and jam timeout; all outputs registered, eject 2 cycles after request.
module change_dispenser
  import soda_machine_types::*;
#(
  parameter int POUR_CYCLES   = DEFAULT_POUR_CYCLES,
  parameter int EJECT_TIMEOUT = DEFAULT_EJECT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic pour_water,
  input  logic change1,
  input  logic change2,
  input  logic change22,
  input  logic sensed1,
  input  logic sensed2,
  output logic eject1,
  output logic eject2,
  output logic valve,
  output logic busy,
  output logic fault
);

  localparam logic [7:0] TMO_LAST = 8'(EJECT_TIMEOUT - 1);

  dispense_state_type state, next_state;
  logic [2:0] cnt1, cnt2, cnt1_next, cnt2_next;
  logic [1:0] inc1, inc2;
  logic       dec1, dec2;
  logic [7:0] tmo;
  logic       last2;
  logic       accept;
  logic       valve_next;

  one_shot_timer #(
    .WIDTH      (8),
    .LOAD_VALUE (POUR_CYCLES)
  ) u_pour_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (pour_water),
    .active      (valve),
    .active_next (valve_next)
  );

  always_comb begin
    next_state = state;
    dec1       = 1'b0;
    dec2       = 1'b0;
    case (state)
      IDLE: begin
        if (cnt2 != 3'd0)      next_state = EJECT2;
        else if (cnt1 != 3'd0) next_state = EJECT1;
      end
      EJECT1: begin
        if (sensed1) begin
          dec1       = 1'b1;
          next_state = GAP;
        end else if (tmo == TMO_LAST) begin
          next_state = FAULT;
        end
      end
      EJECT2: begin
        if (sensed2) begin
          dec2       = 1'b1;
          next_state = GAP;
        end else if (tmo == TMO_LAST) begin
          next_state = FAULT;
        end
      end
      // Hold until the sensor pulse that ended the eject has gone away.
      GAP: begin
        if (!(last2 ? sensed2 : sensed1)) next_state = IDLE;
      end
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase

    accept    = (state != FAULT);
    inc1      = {1'b0, change1 & accept};
    inc2      = {1'b0, change2 & accept} + {change22 & accept, 1'b0};
    cnt1_next = accept ? sat_update(cnt1, inc1, dec1) : cnt1;
    cnt2_next = accept ? sat_update(cnt2, inc2, dec2) : cnt2;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt1   <= 3'd0;
      cnt2   <= 3'd0;
      tmo    <= 8'd0;
      last2  <= 1'b0;
      eject1 <= 1'b0;
      eject2 <= 1'b0;
      fault  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state <= next_state;
      cnt1  <= cnt1_next;
      cnt2  <= cnt2_next;
      if (next_state != state) tmo <= 8'd0;
      else if ((state == EJECT1) || (state == EJECT2)) tmo <= tmo + 8'd1;
      if (state == EJECT1) last2 <= 1'b0;
      else if (state == EJECT2) last2 <= 1'b1;
      eject1 <= (next_state == EJECT1);
      eject2 <= (next_state == EJECT2);
      fault  <= (next_state == FAULT);
      busy   <= valve_next | (cnt1_next != 3'd0) | (cnt2_next != 3'd0) | (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hopper ejects are scored against an expected-order queue,
// valve/fault/reset behaviour checked at fixed points.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pour_water = 1'b0;
  logic change1 = 1'b0;
  logic change2 = 1'b0;
  logic change22 = 1'b0;
  logic auto_sense = 1'b0;
  logic auto_s1 = 1'b0, auto_s2 = 1'b0;
  logic man_s1 = 1'b0, man_s2 = 1'b0;
  logic sensed1, sensed2;
  logic eject1, eject2, valve, busy, fault;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int rise1 = 0;
  int rise2 = 0;

  assign sensed1 = auto_s1 | man_s1;
  assign sensed2 = auto_s2 | man_s2;

  always #5 clk = ~clk;

  change_dispenser #(
    .POUR_CYCLES   (8),
    .EJECT_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pour_water (pour_water),
    .change1    (change1),
    .change2    (change2),
    .change22   (change22),
    .sensed1    (sensed1),
    .sensed2    (sensed2),
    .eject1     (eject1),
    .eject2     (eject2),
    .valve      (valve),
    .busy       (busy),
    .fault      (fault)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; expected hopper order is 2-unit coins before 1-unit coins.
  task automatic req(input logic c1, input logic c2, input logic c22);
    change1  = c1;
    change2  = c2;
    change22 = c22;
    if (c2) exp_q.push_back(2);
    if (c22) begin
      exp_q.push_back(2);
      exp_q.push_back(2);
    end
    if (c1) exp_q.push_back(1);
    tick();
    change1  = 1'b0;
    change2  = 1'b0;
    change22 = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, busy, 0);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    tick();
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, {eject1, eject2, valve, busy, fault}, 0);
    end
    tick();
  endtask

  // Scoreboard: every eject rising edge must match the next expected hopper.
  initial begin
    logic p1, p2;
    int   e;
    p1 = 1'b0;
    p2 = 1'b0;
    forever begin
      @(negedge clk);
      if (eject1 === 1'b1 && !p1) begin
        rise1++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        chk("sb_hopper_order", 1, e);
      end
      if (eject2 === 1'b1 && !p2) begin
        rise2++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        chk("sb_hopper_order", 2, e);
      end
      p1 = (eject1 === 1'b1);
      p2 = (eject2 === 1'b1);
    end
  end

  // Hopper model: sensor answers 3 cycles after the motor starts, for one cycle.
  initial begin
    int hi1, hi2;
    hi1 = 0;
    hi2 = 0;
    forever begin
      @(posedge clk);
      #1;
      hi1 = (eject1 === 1'b1) ? hi1 + 1 : 0;
      hi2 = (eject2 === 1'b1) ? hi2 + 1 : 0;
      auto_s1 = auto_sense && (hi1 >= 4);
      auto_s2 = auto_sense && (hi2 >= 4);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, rises, first, prev;

    // Reset with requests present: they must be discarded.
    reset = 1'b0;
    change1 = 1'b1;
    change2 = 1'b1;
    pour_water = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {eject1, eject2, valve, busy, fault}, 0);
    tick();
    reset = 1'b1;
    change1 = 1'b0;
    change2 = 1'b0;
    pour_water = 1'b0;
    quiet("post_reset_quiet", 4);

    // change22 with answered sensor: two eject2 bursts, no eject1.
    auto_sense = 1'b1;
    rise1 = 0;
    rise2 = 0;
    req(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("eject_latency_cycle1", eject2, 0);
    @(negedge clk);
    chk("eject_latency_cycle2", eject2, 1);
    wait_idle("change22_idle", 100);
    chk("change22_eject2_count", rise2, 2);
    chk("change22_eject1_count", rise1, 0);

    // change1 and change2 together: eject2 first, then eject1, once each.
    rise1 = 0;
    rise2 = 0;
    req(1'b1, 1'b1, 1'b0);
    wait_idle("mixed_idle", 100);
    chk("mixed_eject2_count", rise2, 1);
    chk("mixed_eject1_count", rise1, 1);

    // Stray sensor pulse while idle must not underflow cnt1.
    rise1 = 0;
    man_s1 = 1'b1;
    tick();
    man_s1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_sense_idle", {eject1, eject2, busy}, 0);
    end
    tick();
    req(1'b1, 1'b0, 1'b0);
    wait_idle("stray_follow_idle", 100);
    chk("stray_follow_eject1_count", rise1, 1);

    // Pour, re-pour 5 cycles later: 8 + 5 = 13 contiguous valve cycles.
    n = 0;
    rises = 0;
    first = -1;
    prev = 0;
    for (int i = 0; i < 25; i++) begin
      pour_water = (i == 0) || (i == 5);
      @(negedge clk);
      if (valve) begin
        n++;
        if (!prev) begin
          rises++;
          first = i;
        end
      end
      if (i == 3) chk("pour_busy", busy, 1);
      prev = int'(valve);
      tick();
    end
    pour_water = 1'b0;
    chk("pour_valve_cycles", n, 13);
    chk("pour_valve_contiguous", rises, 1);
    chk("pour_valve_start", first, 1);

    // Eight back-to-back change1 with the sensor held low: only 7 are kept.
    auto_sense = 1'b0;
    rise1 = 0;
    change1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) exp_q.push_back(1);
      tick();
    end
    change1 = 1'b0;
    auto_sense = 1'b1;
    wait_idle("sat_drain_idle", 300);
    chk("sat_eject1_count", rise1, 7);

    // Reset in the middle of an eject with the valve open.
    auto_sense = 1'b0;
    pour_water = 1'b1;
    tick();
    pour_water = 1'b0;
    req(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eject1) break;
    end
    chk("mid_eject_started", eject1, 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_eject_reset_outputs", {eject1, eject2, valve, busy, fault}, 0);
    tick();
    quiet("mid_eject_post_reset", 6);
    chk("mid_eject_sb_empty", exp_q.size(), 0);

    // Unanswered change2: 16 cycles of eject2, then sticky fault.
    rise1 = 0;
    req(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (eject2) break;
    end
    n = 0;
    while (eject2 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("fault_eject2_cycles", n, 16);
    chk("fault_flag", fault, 1);
    chk("fault_eject2_low", eject2, 0);
    tick();
    change1 = 1'b1;
    tick();
    change1 = 1'b0;
    man_s1 = 1'b1;
    tick();
    man_s1 = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("fault_ignores_requests", {eject1, eject2, fault, busy}, 4'b0011);
    chk("fault_no_eject1", rise1, 0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("fault_cleared_by_reset", {eject1, eject2, valve, busy, fault}, 0);
    tick();
    quiet("fault_post_reset", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
